// File: rtl/linear_1d_sync_pkg.sv
// Shared constants and helpers for the linear_1d_sync block family.
// Parameter limits are kept here so every instantiating file agrees on them.
package linear_1d_sync_pkg;

    localparam int unsigned WIDTH_MIN  = 1;
    localparam int unsigned WIDTH_MAX  = 32;
    localparam int unsigned CYCLES_MIN = 2;
    localparam int unsigned CYCLES_MAX = 4;
    localparam int unsigned FILTER_MIN = 1;
    localparam int unsigned FILTER_MAX = 255;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/linear_1d_sync_chan.sv
// One channel: CYCLES-deep synchronizer, FILTER-cycle stability filter,
// and registered rise/fall pulses on each accepted level change.
module linear_1d_sync_chan
    import linear_1d_sync_pkg::*;
#(
    parameter int unsigned CYCLES  = 2,
    parameter int unsigned FILTER  = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW       = clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    (* ASYNC_REG = "TRUE" *) logic [CYCLES-1:0] r_sync = {CYCLES{RST_VAL}};
    logic [CW-1:0] r_cnt  = '0;
    logic          r_filt = RST_VAL;
    logic          r_rise = 1'b0;
    logic          r_fall = 1'b0;
    logic          w_s;

    assign w_s = r_sync[CYCLES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {CYCLES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[CYCLES-2:0], sig_in};
        end
    end

    // Pulses are raised on the same edge filt loads, so they line up with
    // the first cycle sig_out shows the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign sig_out = r_filt;
    assign rise    = r_rise;
    assign fall    = r_fall;

endmodule

// File: rtl/linear_1d_sync_multi.sv
// WIDTH independent synchronize-and-filter channels with edge pulses.
// ACTIVE_HIGH[i]=1 resets channel i to 0, otherwise to 1.
module linear_1d_sync_multi
    import linear_1d_sync_pkg::*;
#(
    parameter int unsigned             WIDTH       = 8,
    parameter int unsigned             CYCLES      = 2,
    parameter int unsigned             FILTER      = 1,
    parameter logic [WIDTH-1:0]        ACTIVE_HIGH = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        linear_1d_sync_chan #(
            .CYCLES  (CYCLES),
            .FILTER  (FILTER),
            .RST_VAL (~ACTIVE_HIGH[i])
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_linear_1d_sync_multi.sv
// Directed bench for linear_1d_sync_multi: main instance (W=4,C=2,F=3,AH=0101)
// and a second instance with FILTER=1, CYCLES=3.
module tb_linear_1d_sync_multi;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sig_in = 4'b1010;
    logic [3:0] sig_out, rise, fall;
    logic [3:0] sig_in2 = 4'b0000;
    logic [3:0] sig_out2, rise2, fall2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    linear_1d_sync_multi #(
        .WIDTH       (4),
        .CYCLES      (2),
        .FILTER      (3),
        .ACTIVE_HIGH (4'b0101)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .rise    (rise),
        .fall    (fall)
    );

    linear_1d_sync_multi #(
        .WIDTH  (4),
        .CYCLES (3),
        .FILTER (1)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in2),
        .sig_out (sig_out2),
        .rise    (rise2),
        .fall    (fall2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] acc_r, acc_f, acc_o;
    int         n_rise, n_fall;

    initial begin
        // Asynchronous reset values, before any clock edge
        #2;
        check("rst_sig_out", 32'(sig_out), 32'h a);
        check("rst_rise_fall", 32'({rise, fall}), 32'h0);
        check("rst_dut2_out", 32'(sig_out2), 32'h0);
        tick(); tick();
        check("rst_sig_out_clk", 32'(sig_out), 32'h a);

        @(negedge clk);
        reset_n = 1'b1;
        acc_r = '0; acc_f = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc_r |= rise; acc_f |= fall;
        end
        check("post_rst_no_rise", 32'(acc_r), 32'h0);
        check("post_rst_no_fall", 32'(acc_f), 32'h0);
        check("post_rst_out", 32'(sig_out), 32'h a);

        // FILTER=1, CYCLES=3: step lands on sig_out2 at the 4th edge
        sig_in2[1] = 1'b1;
        tick(); tick(); tick();
        check("f1_edge3_out", 32'(sig_out2[1]), 32'h0);
        tick();
        check("f1_edge4_out", 32'(sig_out2[1]), 32'h1);
        check("f1_edge4_rise", 32'(rise2), 32'h2);
        tick();
        check("f1_edge5_rise", 32'(rise2), 32'h0);

        // Latency: change after edge k appears after edge k+5
        sig_in[0] = 1'b1;
        acc_f = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            acc_f |= fall;
        end
        check("lat_k4_out", 32'(sig_out[0]), 32'h0);
        tick();
        acc_f |= fall;
        check("lat_k5_out", 32'(sig_out[0]), 32'h1);
        check("lat_k5_rise", 32'(rise), 32'h1);
        tick();
        acc_f |= fall;
        check("lat_k6_rise", 32'(rise[0]), 32'h0);
        check("lat_no_fall", 32'(acc_f), 32'h0);

        // Glitch: sig_in[2] high for 2 cycles is rejected
        sig_in[2] = 1'b1;
        tick(); tick();
        sig_in[2] = 1'b0;
        acc_o = '0; acc_r = '0; acc_f = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc_o |= sig_out; acc_r |= rise; acc_f |= fall;
        end
        check("glitch_out", 32'(acc_o[2]), 32'h0);
        check("glitch_pulses", 32'({acc_r[2], acc_f[2]}), 32'h0);

        // High for 3 cycles is accepted once, then the return to 0 too
        sig_in[2] = 1'b1;
        tick(); tick(); tick();
        sig_in[2] = 1'b0;
        n_rise = 0; n_fall = 0; acc_o = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            acc_o |= sig_out;
            n_rise += int'(rise[2]);
            n_fall += int'(fall[2]);
            if (rise[2] && fall[2]) check("hold3_rise_and_fall", 32'h1, 32'h0);
        end
        check("hold3_out_seen", 32'(acc_o[2]), 32'h1);
        check("hold3_rise_cnt", 32'(n_rise), 32'h1);
        check("hold3_fall_cnt", 32'(n_fall), 32'h1);

        // Independence: restore 1010, then flip all four on one edge
        sig_in = 4'b1010;
        for (int i = 0; i < 10; i++) tick();
        check("indep_pre_out", 32'(sig_out), 32'h a);
        sig_in = 4'b0101;
        acc_r = '0; acc_f = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) begin
                check("indep_rise", 32'(rise), 32'h5);
                check("indep_fall", 32'(fall), 32'h a);
            end else begin
                acc_r |= rise; acc_f |= fall;
            end
        end
        check("indep_other_cycles", 32'({acc_r, acc_f}), 32'h0);
        check("indep_out", 32'(sig_out), 32'h5);

        // Mid-count reset with cnt[0]=1
        sig_in = 4'b1010;
        for (int i = 0; i < 10; i++) tick();
        sig_in[0] = 1'b1;
        tick(); tick(); tick();
        check("midrst_cnt_before", 32'(dut.g_chan[0].u_chan.r_cnt), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(sig_out), 32'h a);
        check("midrst_cnt", 32'(dut.g_chan[0].u_chan.r_cnt), 32'h0);
        check("midrst_pulses", 32'({rise, fall}), 32'h0);
        sig_in = 4'b1010;
        tick(); tick();
        @(negedge clk);
        reset_n = 1'b1;
        acc_r = '0; acc_f = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc_r |= rise; acc_f |= fall;
        end
        check("midrst_after_pulses", 32'({acc_r, acc_f}), 32'h0);
        check("midrst_after_out", 32'(sig_out), 32'h a);

        // Release with sig_in already off its reset value: no release pulse,
        // change arrives through the normal path on the 5th edge
        @(negedge clk);
        reset_n = 1'b0;
        sig_in = 4'b1011;
        @(negedge clk);
        reset_n = 1'b1;
        acc_r = '0; acc_f = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            acc_r |= rise; acc_f |= fall;
        end
        check("rel_no_early_pulse", 32'({acc_r, acc_f}), 32'h0);
        tick();
        check("rel_rise_e5", 32'(rise), 32'h1);
        check("rel_out_e5", 32'(sig_out), 32'h b);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_1d_sync_multi.md
LINEAR_1D_SYNC_MULTI -- requirements
Module: linear_1d_sync_multi

Interface
REQ-001 Parameter WIDTH, default 8: number of independent single-bit channels, 1..32.
REQ-002 Parameter CYCLES, default 2: synchronizer flip-flop stages per channel, 2..4.
REQ-003 Parameter FILTER, default 1: consecutive stable cycles required before the output changes, 1..255; 1 means no filtering.
REQ-004 Parameter ACTIVE_HIGH, default all-ones, WIDTH bits: per-channel polarity; bit 1 resets the channel to 0, bit 0 resets it to 1.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset_n  input  1  reset; asynchronous, active-low.
REQ-007 sig_in  input  WIDTH  asynchronous level inputs, one bit per channel.
REQ-008 sig_out  output  WIDTH  synchronized, filtered levels.
REQ-009 rise  output  WIDTH  one-cycle pulse per channel when sig_out goes 0->1.
REQ-010 fall  output  WIDTH  one-cycle pulse per channel when sig_out goes 1->0.

Function
REQ-011 Each channel shall have a CYCLES-deep flip-flop chain; the chain head samples sig_in[i] on every clk rising edge; s[i] denotes the last stage.
REQ-012 Each channel shall hold a counter cnt[i] of width clog2(FILTER+1) and a state register filt[i] that drives sig_out[i].
REQ-013 When s[i]==filt[i], cnt[i] shall clear to 0 and filt[i] shall hold.
REQ-014 When s[i]!=filt[i] and cnt[i]<FILTER-1, cnt[i] shall increment and filt[i] shall hold.
REQ-015 When s[i]!=filt[i] and cnt[i]==FILTER-1, filt[i] shall load s[i] and cnt[i] shall clear, in the same edge.
REQ-016 cnt[i] shall never exceed FILTER-1; with FILTER=1, filt[i] shall follow s[i] every cycle.
REQ-017 A level change held stable on sig_in shall reach sig_out exactly CYCLES+FILTER clk edges after the first sampling edge.
REQ-018 A change on s[i] that reverts before FILTER consecutive cycles shall produce no change on sig_out[i] and no pulse.
REQ-019 rise[i] shall be registered and high for exactly the one cycle in which sig_out[i] first reads 1 after a 0->1 update; fall[i] behaves the same for a 1->0 update.
REQ-020 rise[i] and fall[i] shall never be high together; channels shall be fully independent, and simultaneous changes on several channels shall each be handled as in REQ-013..REQ-019.

Reset
REQ-021 While reset_n is low, every sync stage and filt[i] shall equal ~ACTIVE_HIGH[i], cnt shall be 0, and rise and fall shall be 0, regardless of clk.
REQ-022 Reset asserted mid-count shall discard the pending count, with no pulse on the following cycles.
REQ-023 Deassertion of reset shall not generate rise or fall pulses, even when sig_in already differs from its reset value; the change propagates per REQ-017.
REQ-024 Registers shall additionally carry declaration initial values equal to their reset values, for FPGA targets.

Structure
REQ-025 The clog2 function and the parameter range limits shall live in shared package linear_1d_sync_pkg.
REQ-026 One sub-module linear_1d_sync_chan (chain, counter, filt, pulse registers for one channel) shall be instantiated WIDTH times by generate.
REQ-027 The chain registers shall carry the synthesis attribute ASYNC_REG.

Verification
REQ-028 The bench shall use WIDTH=4, CYCLES=2, FILTER=3, ACTIVE_HIGH=4'b0101 unless a line states otherwise.
REQ-029 Reset values: hold reset_n low -> sig_out=4'b1010, rise=fall=0; release reset with sig_in=4'b1010 -> no pulses for 20 cycles.
REQ-030 Latency: raise sig_in[0] at edge k -> sig_out[0]=1 and rise[0]=1 for one cycle after edge k+5, fall[0]=0 throughout.
REQ-031 Glitch rejection: toggle sig_in[2] high for 2 cycles then low -> sig_out[2] stays 0 and no pulse; holding it high for 3 cycles -> one update.
REQ-032 Independence: drive sig_in 4'b1010->4'b0101 on one edge -> rise[0], rise[2], fall[1], fall[3] all high in the same single cycle.
REQ-033 Mid-count reset: pulse reset_n low with cnt[0]=1 -> sig_out=4'b1010, cnt=0, no pulses.
REQ-034 FILTER=1, CYCLES=3: a step on sig_in[1] -> sig_out[1] changes after exactly 4 edges.
